y86_stage_sequencer: RTL
========================

// Module: y86_stage_sequencer
// PURPOSE
//  Multi-cycle controller for the Y86 datapath (PC, instruction memory, register file, ALU, data memory).
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPD.
//  Emits one-hot stage enables, runs a req/ready handshake with data memory, and owns the 2-bit stat register.
//  Sits beside CPU top; gates PC, CC, register-file and memory writes.
// PARAMETERS
//  MEM_WAIT_MAX  15  max MEMORY cycles without mem_ready before ADR fault (>=1)
//  CNT_WID       32  width of retired-instruction counter
// PORTS
//  CLK          in   1        clock, rising edge
//  RST_N        in   1        synchronous reset, active-low
//  run          in   1        start/continue execution
//  icode        in   4        instruction code from instruction memory
//  instr_valid  in   1        instruction decodes legally
//  imem_error   in   1        instruction fetch address fault
//  mem_ready    in   1        data memory access complete
//  dmem_error   in   1        data memory address fault, qualified by mem_ready
//  fetch_en     out  1        latch icode/ifun/rA/rB/valC/valP
//  decode_en    out  1        read register file (valA/valB)
//  exec_en      out  1        ALU result valid, CC update allowed
//  mem_req      out  1        data memory request
//  mem_we       out  1        write qualifier for mem_req
//  wb_en        out  1        register file write strobe
//  pc_en        out  1        PC register update strobe
//  stage        out  3        current state encoding
//  stat         out  2        00 AOK, 01 HLT, 10 ADR, 11 INS
//  halted       out  1        high in HALT
//  retired      out  CNT_WID  instructions completed
// BEHAVIOUR
//  State encoding (stage): IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 PCUPD=6 HALT=7.
//  Enables are decoded from the state register only:
//   - fetch_en=FETCH, decode_en=DECODE, exec_en=EXECUTE, mem_req=MEMORY, wb_en=WRITEBACK.
//   - pc_en=PCUPD && icode_q!=0.
//   - mem_we=MEMORY && icode_q in {4,8,A}.
//  Reset (RST_N=0 at an edge): state=IDLE, icode_q=0, wait_cnt=0, stat=00, retired=0; all outputs 0.
//   - Reset dominates everything. Reset mid-instruction abandons it; mem_req drops the next cycle.
//  IDLE: run=1 -> FETCH, else stay.
//  FETCH: icode_q<=icode.
//   - imem_error -> HALT, stat=10.
//   - else !instr_valid -> HALT, stat=11.
//   - else -> DECODE. imem_error has priority over !instr_valid.
//  DECODE -> EXECUTE unconditionally.
//  EXECUTE:
//   - icode_q in {4,5,8,9,A,B} -> MEMORY.
//   - else icode_q in {2,3,6} -> WRITEBACK.
//   - else -> PCUPD.
//  MEMORY: wait_cnt counts cycles spent in the state; it clears on entry.
//   - mem_ready=1 && dmem_error=1 -> HALT, stat=10.
//   - mem_ready=1 && dmem_error=0 -> WRITEBACK if icode_q in {5,8,9,A,B}, else PCUPD.
//   - mem_ready=0 on the MEM_WAIT_MAX-th MEMORY cycle -> HALT, stat=10.
//   - mem_ready may be high on the first MEMORY cycle: single-cycle access.
//   - mem_ready outside MEMORY is ignored.
//  WRITEBACK -> PCUPD.
//  PCUPD: retired<=retired+1 (wraps modulo 2^CNT_WID).
//   - icode_q==0 -> HALT, stat=01, no pc_en.
//   - else run=1 -> FETCH.
//   - else -> IDLE.
//   - Deasserting run mid-instruction never aborts; the instruction completes.
//  HALT: absorbing until reset. halted=1, stat held, all enables 0, run ignored.
//  Faulting instructions are not counted in retired.
//  Latency (cycles FETCH..PCUPD inclusive): nop/jXX 4; rrmov/irmov/OPq 5; rmmov 5+w; mrmov/call/ret/push/pop 6+w.
//   - w = MEMORY cycles before mem_ready, minus 1.
// TESTING
//  1. Reset, run=1, icode=1 x3 -> fetch_en cycles 1,5,9; pc_en cycles 4,8,12; retired=3; stat=00.
//  2. icode=5, mem_ready after 3 low cycles -> mem_req=1 for 4 cycles, mem_we=0, then wb_en 1 cycle, pc_en; 9 cycles total.
//  3. icode=4, mem_ready on first MEMORY cycle -> mem_req=mem_we=1 for 1 cycle, no wb_en, pc_en at cycle 5.
//  4. icode=0 -> no pc_en; retired=1; stat=01; halted=1; toggling run has no effect for 20 cycles.
//  5. Faults:
//   - icode=5, mem_ready held 0 -> HALT after exactly 15 MEMORY cycles, stat=10.
//   - instr_valid=0 -> stat=11.
//   - imem_error=1 with instr_valid=0 -> stat=10.
//  6. RST_N=0 on the 2nd MEMORY cycle -> next cycle stage=0, mem_req=0, retired=0, stat=00; run=1 restarts at FETCH.

Source files
------------

// File: rtl/y86_stage_sequencer.sv
// y86_stage_sequencer
//   Multi-cycle controller for the Y86 datapath. Steps each instruction through
//   FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPD. It emits one-hot stage enables,
//   runs a req/ready handshake with data memory, owns the 2-bit stat register
//   and counts retired instructions.
//
// Ports
//   CLK, RST_N       clock (rising edge), synchronous active-low reset
//   run              start / continue execution
//   icode            instruction code from instruction memory (sampled in FETCH)
//   instr_valid      instruction decodes legally
//   imem_error       instruction fetch address fault
//   mem_ready        data memory access complete (only looked at in MEMORY)
//   dmem_error       data memory address fault, qualified by mem_ready
//   fetch_en..pc_en  stage strobes, decoded from the state register only
//   mem_req/mem_we   data memory request and its write qualifier
//   stage            current state encoding
//   stat             00 AOK, 01 HLT, 10 ADR, 11 INS
//   halted           high in HALT
//   retired          instructions completed (faulting ones excluded)
module y86_stage_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_WID      = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               run,
    input  logic [3:0]         icode,
    input  logic               instr_valid,
    input  logic               imem_error,
    input  logic               mem_ready,
    input  logic               dmem_error,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               mem_req,
    output logic               mem_we,
    output logic               wb_en,
    output logic               pc_en,
    output logic [2:0]         stage,
    output logic [1:0]         stat,
    output logic               halted,
    output logic [CNT_WID-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    // wait_cnt holds (MEMORY cycle index - 1); it only has to reach MEM_WAIT_MAX-1.
    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t              state_q,    state_d;
    logic [3:0]          icode_q,    icode_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]          stat_q,     stat_d;
    logic [CNT_WID-1:0]  retired_q,  retired_d;

    // Instruction classes, all keyed off the latched icode.
    logic uses_mem;   // rmmov, mrmov, call, ret, push, pop
    logic alu_wb;     // rrmov/cmov, irmov, OPq: write back without memory
    logic mem_wb;     // memory ops that also write the register file
    logic mem_store;  // rmmov, call, push

    always_comb begin
        uses_mem  = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        alu_wb    = icode_q inside {4'h2, 4'h3, 4'h6};
        mem_wb    = icode_q inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        mem_store = icode_q inside {4'h4, 4'h8, 4'hA};
    end

    always_comb begin
        state_d    = state_q;
        icode_d    = icode_q;
        wait_cnt_d = '0;          // cleared everywhere except while waiting in MEMORY
        stat_d     = stat_q;
        retired_d  = retired_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (uses_mem)    state_d = S_MEMORY;
                else if (alu_wb) state_d = S_WRITEBACK;
                else             state_d = S_PCUPD;
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else if (mem_wb) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_PCUPD;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // No response within the allowed window: treat as address fault.
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                // halt itself counts as a completed instruction
                retired_d = retired_q + CNT_WID'(1);
                if (icode_q == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            icode_q    <= 4'h0;
            wait_cnt_q <= '0;
            stat_q     <= STAT_AOK;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            icode_q    <= icode_d;
            wait_cnt_q <= wait_cnt_d;
            stat_q     <= stat_d;
            retired_q  <= retired_d;
        end
    end

    // Strobes come straight from the state register so they are glitch-free.
    assign fetch_en  = (state_q == S_FETCH);
    assign decode_en = (state_q == S_DECODE);
    assign exec_en   = (state_q == S_EXECUTE);
    assign mem_req   = (state_q == S_MEMORY);
    assign mem_we    = (state_q == S_MEMORY) && mem_store;
    assign wb_en     = (state_q == S_WRITEBACK);
    assign pc_en     = (state_q == S_PCUPD) && (icode_q != 4'h0);
    assign stage     = state_q;
    assign stat      = stat_q;
    assign halted    = (state_q == S_HALT);
    assign retired   = retired_q;

endmodule
